execute_sequencer: RTL
======================

# execute_sequencer

Sequences the execute stage: accepts decoded instructions from decode over a valid/ready handshake and registers operands. It drives the combinational InstructionExecutor with a one-cycle `execute_enable`, captures its results, and presents them to the memory stage over a second valid/ready handshake. It converts taken branches and jumps into a one-cycle PC redirect pulse and keeps retire and redirect counters.

## Interface
Parameters:
- XLEN, 64, datapath width
- CNT_W, 32, width of performance counters

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- dec_valid  in  1  decode offers an instruction
- dec_ready  out  1  sequencer accepts this cycle
- dec_pc  in  XLEN  PC of offered instruction
- dec_ctrl  in  control_signals_struct  decoded control bundle
- dec_rs1, dec_rs2  in  XLEN  register operand values
- ex_enable  out  1  drives executor `execute_enable`
- ex_pc, ex_rs1, ex_rs2  out  XLEN  registered operands to executor
- ex_ctrl  out  control_signals_struct  registered control bundle to executor
- ex_done  in  1  executor completion
- ex_alu  in  XLEN  executor ALU result
- ex_target  in  XLEN  executor jump/branch target
- ex_ctrl_out  in  control_signals_struct  executor bundle; `jump_signal` valid
- mem_valid  out  1  result available to memory stage
- mem_ready  in  1  memory stage accepts
- mem_alu  out  XLEN  registered ALU result
- mem_ctrl  out  control_signals_struct  registered bundle (includes jump_signal)
- redirect_valid  out  1  one-cycle pulse: fetch must load redirect_pc
- redirect_pc  out  XLEN  redirect target
- retired_cnt  out  CNT_W  count of mem handshakes
- redirect_cnt  out  CNT_W  count of redirect pulses

## Operation
- States: IDLE, EXEC, RESULT.
- IDLE:
  - dec_ready=1.
  - On dec_valid: capture dec_* into ex_* registers and go to EXEC.
- EXEC:
  - ex_enable=1 and dec_ready=0.
  - Stay while ex_done=0.
  - On ex_done: register ex_alu and ex_ctrl_out into mem_alu and mem_ctrl.
  - If ex_ctrl_out.jump_signal=1, also register redirect_pc and arm the redirect.
  - Go to RESULT.
- RESULT:
  - mem_valid=1; mem_alu and mem_ctrl are held stable until mem_ready.
  - redirect_valid=1 only in the first RESULT cycle when armed.
  - dec_ready = mem_ready & ~redirect_valid.
  - On mem_ready with dec_valid and dec_ready: capture the new instruction and go to EXEC.
  - On mem_ready otherwise: go to IDLE.
- Redirect target:
  - JALR (opcode 7'b1100111): ex_target with bit 0 cleared.
  - All other opcodes: ex_target unchanged.
- Wrong-path suppression: no decode instruction is accepted in the redirect cycle. Decode is responsible for dropping its wrong-path entry on redirect_valid.
- Counters:
  - retired_cnt increments on mem_valid & mem_ready.
  - redirect_cnt increments on each redirect_valid cycle.
  - Both wrap modulo 2^CNT_W.
- Non-jump instructions (jump_signal=0) never pulse redirect_valid.

## Timing
- Reset (asynchronous assert, synchronous deassert by upstream):
  - State=IDLE.
  - All outputs 0 except dec_ready=1.
  - ex_*, mem_*, redirect_pc and both counters are 0.
- Reset mid-operation discards the in-flight instruction with no redirect and no retire.
- Latency:
  - Accept in cycle N gives ex_enable in N+1.
  - With ex_done in N+1, mem_valid (and redirect_valid if taken) appear in N+2.
- Throughput: one instruction per 2 cycles when mem_ready=1 and no redirects.
- Backpressure: mem_ready=0 holds RESULT indefinitely, with outputs stable and dec_ready=0. redirect_valid still pulses only once.
- Taken jump with mem_ready=1 in the redirect cycle: retire occurs, no acceptance, next state IDLE.
- ex_done delayed k cycles keeps ex_enable high for k+1 cycles.

## Structure
- Shared package `exec_seq_pkg` contains:
  - enum `exec_seq_state_e` {IDLE, EXEC, RESULT}
  - opcode constants OPC_BRANCH=7'b1100011, OPC_JAL=7'b1101111, OPC_JALR=7'b1100111
- control_signals_struct comes from the existing shared header.
- One natural sub-module: `perf_counter` (CNT_W-bit wrapping counter with increment enable and async active-low reset), instantiated twice.

## Test plan
- Reset then single ADD (dec_valid one cycle, ex_done immediate, mem_ready=1): ex_enable in cycle 1; mem_valid in cycle 2 with mem_alu=ex_alu; redirect_valid=0; retired_cnt=1.
- Taken BEQ with ex_target=0x1000: redirect_valid=1 for exactly one cycle with redirect_pc=0x1000; dec_ready=0 that cycle despite dec_valid=1; redirect_cnt=1.
- JALR with ex_target=0x2003: redirect_pc=0x2002.
- mem_ready low for 5 cycles in RESULT: mem_alu and mem_ctrl are stable, dec_ready=0, single redirect pulse; retire occurs on the cycle mem_ready rises.
- Back-to-back 4 non-jump instructions with dec_valid and mem_ready held high: accepts in cycles 0, 2, 4, 6; retired_cnt=4 after cycle 8.
- reset asserted during EXEC: all outputs 0 immediately (asynchronously), dec_ready=1 after release, counters 0; retired_cnt=2^CNT_W−1 preload test wraps to 0 on next retire.

Source files
------------

// File: rtl/exec_seq_pkg.sv
// Shared types and constants for the execute-stage sequencer.
// Holds the state enum, RISC-V control-flow opcodes and the decoded control bundle.
package exec_seq_pkg;

   typedef enum logic [1:0] {
      IDLE,
      EXEC,
      RESULT
   } exec_seq_state_e;

   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;

   typedef struct packed {
      logic [6:0] opcode;
      logic [2:0] funct3;
      logic [4:0] rd;
      logic       reg_write;
      logic       mem_read;
      logic       mem_write;
      logic       jump_signal;
   } control_signals_struct;

endpackage

// File: rtl/perf_counter.sv
// Free-running wrapping event counter with an increment enable.
module perf_counter #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   logic [CNT_W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (inc) count_d = count_q + 1'b1;
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) count_q <= '0;
      else        count_q <= count_d;
   end

   assign count = count_q;

endmodule

// File: rtl/execute_sequencer.sv
// Execute-stage sequencer: decode handshake in, executor drive, memory handshake out,
// plus a one-cycle PC redirect pulse for taken control flow and two perf counters.
module execute_sequencer
   import exec_seq_pkg::*;
#(
   parameter int XLEN  = 64,
   parameter int CNT_W = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  dec_valid,
   output logic                  dec_ready,
   input  logic [XLEN-1:0]       dec_pc,
   input  control_signals_struct dec_ctrl,
   input  logic [XLEN-1:0]       dec_rs1,
   input  logic [XLEN-1:0]       dec_rs2,
   output logic                  ex_enable,
   output logic [XLEN-1:0]       ex_pc,
   output logic [XLEN-1:0]       ex_rs1,
   output logic [XLEN-1:0]       ex_rs2,
   output control_signals_struct ex_ctrl,
   input  logic                  ex_done,
   input  logic [XLEN-1:0]       ex_alu,
   input  logic [XLEN-1:0]       ex_target,
   input  control_signals_struct ex_ctrl_out,
   output logic                  mem_valid,
   input  logic                  mem_ready,
   output logic [XLEN-1:0]       mem_alu,
   output control_signals_struct mem_ctrl,
   output logic                  redirect_valid,
   output logic [XLEN-1:0]       redirect_pc,
   output logic [CNT_W-1:0]      retired_cnt,
   output logic [CNT_W-1:0]      redirect_cnt
);

   exec_seq_state_e       state_q, state_d;
   logic [XLEN-1:0]       ex_pc_q, ex_pc_d;
   logic [XLEN-1:0]       ex_rs1_q, ex_rs1_d;
   logic [XLEN-1:0]       ex_rs2_q, ex_rs2_d;
   control_signals_struct ex_ctrl_q, ex_ctrl_d;
   logic [XLEN-1:0]       mem_alu_q, mem_alu_d;
   control_signals_struct mem_ctrl_q, mem_ctrl_d;
   logic [XLEN-1:0]       redirect_pc_q, redirect_pc_d;
   logic                  armed_q, armed_d;

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      state_d        = state_q;
      ex_pc_d        = ex_pc_q;
      ex_rs1_d       = ex_rs1_q;
      ex_rs2_d       = ex_rs2_q;
      ex_ctrl_d      = ex_ctrl_q;
      mem_alu_d      = mem_alu_q;
      mem_ctrl_d     = mem_ctrl_q;
      redirect_pc_d  = redirect_pc_q;
      armed_d        = armed_q;
      dec_ready      = 1'b0;
      ex_enable      = 1'b0;
      mem_valid      = 1'b0;
      redirect_valid = 1'b0;

      case (state_q)
         IDLE: begin
            dec_ready = 1'b1;
         end
         EXEC: begin
            ex_enable = 1'b1;
            if (ex_done) begin
               mem_alu_d  = ex_alu;
               mem_ctrl_d = ex_ctrl_out;
               armed_d    = ex_ctrl_out.jump_signal;
               if (ex_ctrl_out.jump_signal) begin
                  redirect_pc_d = (ex_ctrl_out.opcode == OPC_JALR) ?
                                  (ex_target & ~XLEN'(1)) : ex_target;
               end
               state_d = RESULT;
            end
         end
         RESULT: begin
            mem_valid      = 1'b1;
            // The redirect fires only on the first RESULT cycle, even under backpressure.
            redirect_valid = armed_q;
            armed_d        = 1'b0;
            dec_ready      = mem_ready & ~armed_q;
            if (mem_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Acceptance is shared by IDLE and a retiring RESULT; wrong-path entries are refused while redirecting.
      if (dec_valid && dec_ready) begin
         ex_pc_d   = dec_pc;
         ex_rs1_d  = dec_rs1;
         ex_rs2_d  = dec_rs2;
         ex_ctrl_d = dec_ctrl;
         state_d   = EXEC;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= IDLE;
         ex_pc_q       <= '0;
         ex_rs1_q      <= '0;
         ex_rs2_q      <= '0;
         ex_ctrl_q     <= '0;
         mem_alu_q     <= '0;
         mem_ctrl_q    <= '0;
         redirect_pc_q <= '0;
         armed_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         ex_pc_q       <= ex_pc_d;
         ex_rs1_q      <= ex_rs1_d;
         ex_rs2_q      <= ex_rs2_d;
         ex_ctrl_q     <= ex_ctrl_d;
         mem_alu_q     <= mem_alu_d;
         mem_ctrl_q    <= mem_ctrl_d;
         redirect_pc_q <= redirect_pc_d;
         armed_q       <= armed_d;
      end
   end

   assign ex_pc       = ex_pc_q;
   assign ex_rs1      = ex_rs1_q;
   assign ex_rs2      = ex_rs2_q;
   assign ex_ctrl     = ex_ctrl_q;
   assign mem_alu     = mem_alu_q;
   assign mem_ctrl    = mem_ctrl_q;
   assign redirect_pc = redirect_pc_q;

   perf_counter #(.CNT_W(CNT_W)) u_retired_cnt (
      .clk   (clk),
      .rst_n (reset),
      .inc   (mem_valid & mem_ready),
      .count (retired_cnt)
   );

   perf_counter #(.CNT_W(CNT_W)) u_redirect_cnt (
      .clk   (clk),
      .rst_n (reset),
      .inc   (redirect_valid),
      .count (redirect_cnt)
   );

endmodule
